// File: rtl/chip8_pkg.sv
// Shared opcode encodings for the CHIP-8 decode pipeline.
package chip8_pkg;
  localparam int OP_MIN_W = 6;

  localparam logic [5:0] OP_NOP       = 6'd0;
  localparam logic [5:0] OP_CLS       = 6'd1;
  localparam logic [5:0] OP_RET       = 6'd2;
  localparam logic [5:0] OP_JP        = 6'd3;
  localparam logic [5:0] OP_CALL      = 6'd4;
  localparam logic [5:0] OP_SE_VX_NN  = 6'd5;
  localparam logic [5:0] OP_SNE_VX_NN = 6'd6;
  localparam logic [5:0] OP_SE_VX_VY  = 6'd7;
  localparam logic [5:0] OP_LD_VX_NN  = 6'd8;
  localparam logic [5:0] OP_ADD_VX_NN = 6'd9;
  localparam logic [5:0] OP_LD_VX_VY  = 6'd10;
  localparam logic [5:0] OP_OR        = 6'd11;
  localparam logic [5:0] OP_AND       = 6'd12;
  localparam logic [5:0] OP_XOR       = 6'd13;
  localparam logic [5:0] OP_ADD_VX_VY = 6'd14;
  localparam logic [5:0] OP_SUB       = 6'd15;
  localparam logic [5:0] OP_SHR       = 6'd16;
  localparam logic [5:0] OP_SUBN      = 6'd17;
  localparam logic [5:0] OP_SHL       = 6'd18;
  localparam logic [5:0] OP_SNE_VX_VY = 6'd19;
  localparam logic [5:0] OP_LD_I      = 6'd20;
  localparam logic [5:0] OP_JP_V0     = 6'd21;
  localparam logic [5:0] OP_RND       = 6'd22;
  localparam logic [5:0] OP_DRW       = 6'd23;
  localparam logic [5:0] OP_SKP       = 6'd24;
  localparam logic [5:0] OP_SKNP      = 6'd25;
  localparam logic [5:0] OP_LD_VX_DT  = 6'd26;
  localparam logic [5:0] OP_LD_VX_K   = 6'd27;
  localparam logic [5:0] OP_LD_DT_VX  = 6'd28;
  localparam logic [5:0] OP_LD_ST_VX  = 6'd29;
  localparam logic [5:0] OP_ADD_I_VX  = 6'd30;
  localparam logic [5:0] OP_LD_F_VX   = 6'd31;
  localparam logic [5:0] OP_LD_B_VX   = 6'd32;
  localparam logic [5:0] OP_LD_I_VX   = 6'd33;
  localparam logic [5:0] OP_LD_VX_I   = 6'd34;
  localparam logic [5:0] OP_SCD       = 6'd35;
  localparam logic [5:0] OP_SCR       = 6'd36;
  localparam logic [5:0] OP_SCL       = 6'd37;
  localparam logic [5:0] OP_EXIT      = 6'd38;
  localparam logic [5:0] OP_LOW       = 6'd39;
  localparam logic [5:0] OP_HIGH      = 6'd40;
  localparam logic [5:0] OP_LD_HF     = 6'd41;
  localparam logic [5:0] OP_LD_R      = 6'd42;
  localparam logic [5:0] OP_LD_VX_R   = 6'd43;
endpackage

// File: rtl/chip8_decode_comb.sv
// Combinational CHIP-8 / SUPER-CHIP instruction word -> {op, illegal}.
module chip8_decode_comb
  import chip8_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter bit SCHIP_EN = 1'b0
) (
  input  logic [15:0]     instr,
  output logic [OP_W-1:0] op,
  output logic            illegal
);
  logic [5:0] w_code;
  logic       w_ill;
  logic       w_sc;

  assign w_sc = SCHIP_EN;

  always_comb begin
    w_code = OP_NOP;
    w_ill  = 1'b0;
    case (instr[15:12])
      4'h0: begin
        // SUPER-CHIP encodings decode normally but are flagged when disabled
        case (instr[11:0])
          12'h0E0: w_code = OP_CLS;
          12'h0EE: w_code = OP_RET;
          12'h0FB: begin w_code = OP_SCR;  w_ill = !w_sc; end
          12'h0FC: begin w_code = OP_SCL;  w_ill = !w_sc; end
          12'h0FD: begin w_code = OP_EXIT; w_ill = !w_sc; end
          12'h0FE: begin w_code = OP_LOW;  w_ill = !w_sc; end
          12'h0FF: begin w_code = OP_HIGH; w_ill = !w_sc; end
          default: begin
            w_code = OP_SCD;
            w_ill  = !(w_sc && instr[11:4] == 8'h0C);
          end
        endcase
      end
      4'h1: w_code = OP_JP;
      4'h2: w_code = OP_CALL;
      4'h3: w_code = OP_SE_VX_NN;
      4'h4: w_code = OP_SNE_VX_NN;
      4'h5: begin w_code = OP_SE_VX_VY; w_ill = instr[3:0] != 4'h0; end
      4'h6: w_code = OP_LD_VX_NN;
      4'h7: w_code = OP_ADD_VX_NN;
      4'h8: begin
        if (!instr[3])                w_code = OP_LD_VX_VY + 6'(instr[2:0]);
        else if (instr[3:0] == 4'hE)  w_code = OP_SHL;
        else                          w_ill  = 1'b1;
      end
      4'h9: begin w_code = OP_SNE_VX_VY; w_ill = instr[3:0] != 4'h0; end
      4'hA: w_code = OP_LD_I;
      4'hB: w_code = OP_JP_V0;
      4'hC: w_code = OP_RND;
      4'hD: w_code = OP_DRW;
      4'hE: begin
        case (instr[7:0])
          8'h9E:   w_code = OP_SKP;
          8'hA1:   w_code = OP_SKNP;
          default: w_ill  = 1'b1;
        endcase
      end
      default: begin
        case (instr[7:0])
          8'h07:   w_code = OP_LD_VX_DT;
          8'h0A:   w_code = OP_LD_VX_K;
          8'h15:   w_code = OP_LD_DT_VX;
          8'h18:   w_code = OP_LD_ST_VX;
          8'h1E:   w_code = OP_ADD_I_VX;
          8'h29:   w_code = OP_LD_F_VX;
          8'h33:   w_code = OP_LD_B_VX;
          8'h55:   w_code = OP_LD_I_VX;
          8'h65:   w_code = OP_LD_VX_I;
          8'h30:   begin w_code = OP_LD_HF;   w_ill = !w_sc; end
          8'h75:   begin w_code = OP_LD_R;    w_ill = !w_sc; end
          8'h85:   begin w_code = OP_LD_VX_R; w_ill = !w_sc; end
          default: w_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign op      = w_ill ? OP_W'(OP_NOP) : OP_W'(w_code);
  assign illegal = w_ill;
endmodule

// File: rtl/chip8_decode_pipe.sv
// Handshaked CHIP-8 decoder: decode on push, 2-entry output FIFO, flush and
// saturating illegal-word counter. OP_W must be at least chip8_pkg::OP_MIN_W.
module chip8_decode_pipe
  import chip8_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int OP_W      = 6,
  parameter bit SCHIP_EN  = 1'b0,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      out_op,
  output logic                 out_illegal,
  output logic [3:0]           out_x,
  output logic [3:0]           out_y,
  output logic [3:0]           out_n,
  output logic [7:0]           out_nn,
  output logic [ADDR_W-1:0]    out_nnn,
  output logic [ILL_CNT_W-1:0] ill_count
);
  logic [OP_W-1:0]       w_op;
  logic                  w_ill;
  logic                  w_push;
  logic                  w_pop;
  logic [0:0]            w_widx;

  logic [1:0]            r_cnt;
  logic [1:0][OP_W-1:0]  r_op;
  logic [1:0]            r_ill;
  logic [1:0][11:0]      r_fld;
  logic [ILL_CNT_W-1:0]  r_ill_cnt;

  chip8_decode_comb #(.OP_W(OP_W), .SCHIP_EN(SCHIP_EN)) u_dec (
    .instr   (in_instr),
    .op      (w_op),
    .illegal (w_ill)
  );

  assign in_ready  = !rst && (r_cnt != 2'd2);
  assign out_valid = (r_cnt != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // Slot the new entry lands in once any head pop has shifted the queue
  assign w_widx    = 1'(r_cnt - {1'b0, w_pop});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_ill     <= '0;
      r_fld     <= '0;
      r_ill_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_op[0]  <= r_op[1];
        r_ill[0] <= r_ill[1];
        r_fld[0] <= r_fld[1];
      end
      if (w_push) begin
        r_op[w_widx]  <= w_op;
        r_ill[w_widx] <= w_ill;
        r_fld[w_widx] <= in_instr[11:0];
        if (w_ill && !(&r_ill_cnt)) r_ill_cnt <= r_ill_cnt + 1'b1;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign out_op      = r_op[0];
  assign out_illegal = r_ill[0];
  assign out_x       = r_fld[0][11:8];
  assign out_y       = r_fld[0][7:4];
  assign out_n       = r_fld[0][3:0];
  assign out_nn      = r_fld[0][7:0];
  assign out_nnn     = ADDR_W'(r_fld[0]);
  assign ill_count   = r_ill_cnt;
endmodule

// File: tb/tb_chip8_decode_pipe.sv
// Scoreboard bench: dut A (base ISA, 16-bit nnn) and dut B (SUPER-CHIP, 2-bit counter) share inputs.
module tb_chip8_decode_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic out_ready = 1'b0;

  logic a_in_ready, a_out_valid, a_ill;
  logic [5:0] a_op;
  logic [3:0] a_x, a_y, a_n;
  logic [7:0] a_nn;
  logic [15:0] a_nnn;
  logic [7:0] a_cnt;

  logic b_in_ready, b_out_valid, b_ill;
  logic [5:0] b_op;
  logic [3:0] b_x, b_y, b_n;
  logic [7:0] b_nn;
  logic [11:0] b_nnn;
  logic [1:0] b_cnt;

  logic [5:0] e_op = 6'd0;
  logic       e_ill = 1'b0;

  typedef struct packed { logic [5:0] op; logic ill; logic [15:0] w; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  chip8_decode_pipe #(.ADDR_W(16), .OP_W(6), .SCHIP_EN(1'b0), .ILL_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready), .out_op(a_op),
    .out_illegal(a_ill), .out_x(a_x), .out_y(a_y), .out_n(a_n), .out_nn(a_nn),
    .out_nnn(a_nnn), .ill_count(a_cnt));

  chip8_decode_pipe #(.ADDR_W(12), .OP_W(6), .SCHIP_EN(1'b1), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready), .out_op(b_op),
    .out_illegal(b_ill), .out_x(b_x), .out_y(b_y), .out_n(b_n), .out_nn(b_nn),
    .out_nnn(b_nnn), .ill_count(b_cnt));

  // Scoreboard on dut A: expectation queued at accept, compared at pop
  always @(negedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      if (a_out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got op=%0d word fields x=%h nn=%h, expected nothing", a_op, a_x, a_nn);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({a_op, a_ill, a_x, a_y, a_n, a_nn, a_nnn} !==
              {e.op, e.ill, e.w[11:8], e.w[7:4], e.w[3:0], e.w[7:0], {4'h0, e.w[11:0]}}) begin
            bad++;
            $display("FAIL sb_head %h: got op=%0d ill=%b x=%h y=%h n=%h nn=%h nnn=%h, expected op=%0d ill=%b",
                     e.w, a_op, a_ill, a_x, a_y, a_n, a_nn, a_nnn, e.op, e.ill);
          end
        end
      end
      if (in_valid && a_in_ready) q.push_back('{op: e_op, ill: e_ill, w: in_instr});
    end
  end

  task automatic push(input logic [15:0] w, input logic [5:0] op, input logic ill);
    bit ok = 0;
    in_valid = 1'b1; in_instr = w; e_op = op; e_ill = ill;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      bad++; total++;
      $display("FAIL push_timeout %h: in_ready=0, expected 1 within 50 cycles", w);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!a_out_valid) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b, expected 0", a_in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_out_valid, a_in_ready, a_cnt, a_op, a_ill, a_nnn} !== {1'b0, 1'b1, 8'd0, 6'd0, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL reset_state: got valid=%b ready=%b cnt=%0d op=%0d ill=%b nnn=%h, expected 0 1 0 0 0 0",
               a_out_valid, a_in_ready, a_cnt, a_op, a_ill, a_nnn);
    end
    total++;
    if ({b_out_valid, b_in_ready, b_cnt} !== {1'b0, 1'b1, 2'd0}) begin
      bad++; $display("FAIL reset_b: got valid=%b ready=%b cnt=%0d, expected 0 1 0", b_out_valid, b_in_ready, b_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(16'h6A3F, 6'd8, 1'b0);
    @(negedge clk);
    total++;
    if (a_out_valid !== 1'b1) begin bad++; $display("FAIL latency: out_valid=%b, expected 1", a_out_valid); end
    @(posedge clk); #1;
    push(16'hD125, 6'd23, 1'b0);
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(16'h1234, 6'd3, 1'b0);
    push(16'h2456, 6'd4, 1'b0);
    in_valid = 1'b1; in_instr = 16'h00E0; e_op = 6'd1; e_ill = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({a_in_ready, a_out_valid, a_op, a_nnn} !== {1'b0, 1'b1, 6'd3, 16'h0234}) begin
        bad++;
        $display("FAIL stall_hold: got ready=%b valid=%b op=%0d nnn=%h, expected 0 1 3 0234",
                 a_in_ready, a_out_valid, a_op, a_nnn);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(16'h00E0, 6'd1, 1'b0);
    drain();
    total++;
    if (a_out_valid !== 1'b0 || q.size() != 0) begin
      bad++; $display("FAIL bp_drain: valid=%b pending=%0d, expected 0 0", a_out_valid, q.size());
    end
  endtask

  task automatic test_illegal();
    logic [15:0] w[3] = '{16'h00FF, 16'hF375, 16'h5121};
    logic [5:0]  bop[3] = '{6'd40, 6'd42, 6'd0};
    logic        bil[3] = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(w[i], 6'd0, 1'b1);
      @(negedge clk);
      total++;
      if ({b_op, b_ill} !== {bop[i], bil[i]}) begin
        bad++; $display("FAIL schip %h: got op=%0d ill=%b, expected op=%0d ill=%b", w[i], b_op, b_ill, bop[i], bil[i]);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
    end
    @(negedge clk);
    total++;
    if ({a_cnt, b_cnt} !== {8'd3, 2'd1}) begin
      bad++; $display("FAIL ill_count: got a=%0d b=%0d, expected a=3 b=1", a_cnt, b_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(16'h6111, 6'd8, 1'b0);
    push(16'h7222, 6'd9, 1'b0);
    in_valid = 1'b1; in_instr = 16'h8AB4; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      bad++; $display("FAIL flush_full: got valid=%b ready=%b, expected 0 1", a_out_valid, a_in_ready);
    end
    @(posedge clk); #1;
    push(16'h6111, 6'd8, 1'b0);
    in_valid = 1'b1; in_instr = 16'hE000; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({a_out_valid, a_cnt, b_cnt} !== {1'b0, 8'd3, 2'd1}) begin
      bad++; $display("FAIL flush_push: got valid=%b a_cnt=%0d b_cnt=%0d, expected 0 3 1", a_out_valid, a_cnt, b_cnt);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(16'h8AB4, 6'd14, 1'b0);
    drain();
    total++;
    if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_resume: valid=%b, expected 0", a_out_valid); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(16'hE000, 6'd0, 1'b1);
    drain();
    total++;
    if ({a_cnt, b_cnt} !== {8'd8, 2'd3}) begin
      bad++; $display("FAIL saturate: got a=%0d b=%0d, expected a=8 b=3", a_cnt, b_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[26] = '{16'h8120, 16'h8121, 16'h8122, 16'h8123, 16'h8124, 16'h8125, 16'h8126,
                           16'h8127, 16'h812E, 16'h9120, 16'hA123, 16'hB123, 16'hC1FF, 16'hE19E,
                           16'hE1A1, 16'hF107, 16'hF10A, 16'hF115, 16'hF118, 16'hF11E, 16'hF129,
                           16'hF133, 16'hF155, 16'hF165, 16'h812F, 16'h9121};
    logic [5:0] op[26] = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd19,
                           6'd20, 6'd21, 6'd22, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd30,
                           6'd31, 6'd32, 6'd33, 6'd34, 6'd0, 6'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 26; i++) push(w[i], op[i], i >= 24);
    push(16'h00EE, 6'd2, 1'b0);
    push(16'h3122, 6'd5, 1'b0);
    push(16'h4122, 6'd6, 1'b0);
    push(16'h5120, 6'd7, 1'b0);
    drain();
    total++;
    if ({a_cnt, b_cnt, a_out_valid} !== {8'd10, 2'd3, 1'b0}) begin
      bad++; $display("FAIL b2b_end: got a=%0d b=%0d valid=%b, expected 10 3 0", a_cnt, b_cnt, a_out_valid);
    end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    push(16'h6A3F, 6'd8, 1'b0);
    push(16'h1234, 6'd3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready: got %b, expected 0", a_in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_out_valid, a_in_ready, a_cnt, b_cnt, a_op, a_x, a_nnn} !==
        {1'b0, 1'b1, 8'd0, 2'd0, 6'd0, 4'd0, 16'h0}) begin
      bad++;
      $display("FAIL rst_mid: got valid=%b ready=%b a=%0d b=%0d op=%0d x=%h nnn=%h, expected 0 1 0 0 0 0 0",
               a_out_valid, a_in_ready, a_cnt, b_cnt, a_op, a_x, a_nnn);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_flush();
    test_saturate();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/chip8_decode_pipe.md
Name: chip8_decode_pipe

Overview:
- Parametrised, handshaked successor to the CHIP-8 instruction decoder.
- Accepts 16-bit instruction words from fetch over valid/ready and decodes them to an opcode enum plus operand fields.
- Buffers decoded results in a 2-entry output FIFO (skid), so fetch and execute stall independently.
- Adds illegal-opcode flagging, pipeline flush for taken branches, optional SUPER-CHIP decoding and a saturating illegal-instruction counter.

Parameters:
- ADDR_W, 12, width of nnn output; nnn is zero-extended from instr[11:0]; legal range 12..16.
- OP_W, 6, width of op output; must be >= 6.
- SCHIP_EN, 0, 1 = decode SUPER-CHIP extensions; 0 = those encodings are illegal.
- ILL_CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered entries this cycle
- in_valid  in  1  instruction word present
- in_ready  out  1  block can accept a word
- in_instr  in  16  instruction word, most significant byte first: opcode nibble in [15:12]
- out_valid  out  1  decoded entry at head
- out_ready  in  1  execute consumes head
- out_op  out  OP_W  opcode enum from chip8_pkg
- out_illegal  out  1  head entry is undefined; out_op = OP_NOP in that case
- out_x  out  4  instr[11:8]
- out_y  out  4  instr[7:4]
- out_n  out  4  instr[3:0]
- out_nn  out  8  instr[7:0]
- out_nnn  out  ADDR_W  instr[11:0], zero-extended
- ill_count  out  ILL_CNT_W  count of illegal words accepted; saturates at all-ones

Behaviour:
- Reset: all out_* signals and ill_count = 0; buffer empty. in_ready = 0 while rst is high and 1 on the first cycle after.
- Field extraction: x, y, n, nn and nnn are always taken raw from the word, regardless of op; execute ignores fields it does not use.
- Decode map:
  - 00E0 CLS=1; 00EE RET=2; 1nnn JP=3; 2nnn CALL=4.
  - 3xnn SE_VX_NN=5; 4xnn SNE_VX_NN=6; 5xy0 SE_VX_VY=7 (low nibble must be 0).
  - 6xnn LD_VX_NN=8; 7xnn ADD_VX_NN=9.
  - 8xy0..8xy7 = 10..17 (LD, OR, AND, XOR, ADD, SUB, SHR, SUBN); 8xyE SHL=18.
  - 9xy0 SNE_VX_VY=19; Annn LD_I=20; Bnnn JP_V0=21; Cxnn RND=22; Dxyn DRW=23.
  - Ex9E SKP=24; ExA1 SKNP=25.
  - Fx07=26, Fx0A=27, Fx15=28, Fx18=29, Fx1E=30, Fx29=31, Fx33=32, Fx55=33, Fx65=34.
  - With SCHIP_EN=1: 00Cn SCD=35, 00FB SCR=36, 00FC SCL=37, 00FD EXIT=38, 00FE LOW=39, 00FF HIGH=40, Fx30 LD_HF=41, Fx75 LD_R=42, Fx85 LD_VX_R=43.
  - Every other encoding, including other 0nnn (SYS) words: out_illegal=1, op=OP_NOP=0.
- Handshake:
  - Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
  - in_ready = (count < 2), registered from count.
  - out_valid = (count != 0).
  - Head outputs hold stable while out_valid && !out_ready.
- Latency: a word pushed into an empty buffer appears on out_* the next cycle. Order is strictly FIFO.
- Simultaneous events:
  - push+pop at count 1: count stays 1; the new entry becomes head next cycle.
  - push+pop at count 0: no pop possible.
  - count 2: in_ready = 0, so no push.
- flush: count becomes 0 next cycle, and a same-cycle push is also discarded. It has priority over push and pop; it does not affect ill_count.
- ill_count increments on push of an illegal word (not counted if flushed the same cycle). Holds at max.
- rst mid-operation: buffer contents are lost, and all outputs return to their reset values the next cycle.

Decomposition:
- chip8_pkg holds the OP_* localparams (OP_NOP=0 through OP_LD_VX_R=43) and the OP_W minimum.
- One sub-module, chip8_decode_comb: purely combinational instr -> {op, illegal}, with the SCHIP_EN parameter.
- chip8_decode_pipe instantiates chip8_decode_comb and adds the 2-entry buffer, handshake, flush and counter.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, ill_count=0.
- Push 0x6A3F, out_ready=1 -> next cycle out_op=8, x=0xA, nn=0x3F, out_illegal=0; push 0xD125 -> op=23, x=1, y=2, n=5.
- out_ready=0, push 0x1234, 0x2456, then offer 0x00E0 -> first two accepted, in_ready=0, third stalls; release out_ready -> heads 3 (nnn=0x234), 4, 1 in order.
- SCHIP_EN=0: push 0x00FF and 0x5121 -> out_illegal=1, op=0, ill_count=2; SCHIP_EN=1: 0x00FF -> op=40, 0xF375 -> op=42, 0x5121 still illegal.
- Count=2, assert flush with in_valid (0x8AB4) -> next cycle out_valid=0, count=0, 0x8AB4 discarded.
- ILL_CNT_W=2: push 5 illegal words (0xE000) -> ill_count saturates at 3; rst mid-stream -> out_valid=0, ill_count=0.
